// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the fifo write-port arbiter and its
// round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Index width for an n-entry requester vector (never narrower than 1 bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat counter must be able to hold max_beats itself.
  function automatic int cnt_w(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping past N-1 back to 0.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found_o && req_i[(int'(ptr_i) + k) % N]) begin
        found_o = 1'b1;
        idx_o   = IW'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NREQ packet producers;
// a grant lasts until `last` or MAX_BEATS beats, whichever comes first.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     fifo_write,
  output logic [WIDTH-1:0]         fifo_din,
  input  logic                     fifo_full,
  output logic                     busy,
  output logic [idx_w(NREQ)-1:0]   grant_id,
  output logic                     trunc_pulse
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = cnt_w(MAX_BEATS);

  logic [NREQ-1:0][WIDTH-1:0] data_v;
  arb_state_e                 state_q, state_d;
  logic [IW-1:0]              grant_q, grant_d, rr_q, rr_d;
  logic [IW-1:0]              pick_idx, grant_nxt;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       trunc_q, trunc_d;
  logic                       pick_found, beat;

  assign data_v = req_data;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Explicit wrap so non-power-of-two NREQ never yields an out-of-range pointer.
  assign grant_nxt = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  assign beat        = (state_q == LOCK) && req_valid[grant_q] && !fifo_full;
  assign fifo_write  = beat;
  assign fifo_din    = beat ? data_v[grant_q] : '0;
  assign busy        = (state_q == LOCK);
  assign grant_id    = grant_q;
  assign trunc_pulse = trunc_q;

  always_comb begin
    req_ready          = '0;
    req_ready[grant_q] = beat;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    trunc_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          // last wins over the cap, so a packet of exactly MAX_BEATS is not truncation
          if (req_last[grant_q]) begin
            state_d = IDLE;
            rr_d    = grant_nxt;
          end else if (cnt_q + 1'b1 == CW'(MAX_BEATS)) begin
            state_d = IDLE;
            rr_d    = grant_nxt;
            trunc_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-requester producer queues feed
// the DUT, a scoreboard of expected fifo words is checked on every write.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int MAXB  = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_last = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_write;
  logic [WIDTH-1:0]      fifo_din;
  logic                  fifo_full = 1'b0;
  logic                  busy;
  logic [1:0]            grant_id;
  logic                  trunc_pulse;

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BEATS(MAXB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_write  (fifo_write),
    .fifo_din    (fifo_din),
    .fifo_full   (fifo_full),
    .busy        (busy),
    .grant_id    (grant_id),
    .trunc_pulse (trunc_pulse)
  );

  always #5 clk = ~clk;

  logic [8:0]      pq [NREQ][$];  // {last, data} per producer
  logic [7:0]      sb [$];        // expected fifo words in order
  int              cyc_q [$];
  logic [NREQ-1:0] acc = '0;
  logic [NREQ-1:0] hold = '0;
  logic            full_req = 1'b0;
  logic [7:0]      mon_exp;
  int checks = 0, failures = 0, wr_count = 0, trunc_cnt = 0, trunc_at = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every fifo write is popped and compared.
  always @(negedge clk) begin
    if (!rst_n) acc = '0;
    else begin
      acc = req_valid & req_ready;
      if (fifo_write) begin
        wr_count++;
        cyc_q.push_back(cyc);
        checks++;
        if (fifo_full) begin
          failures++;
          $display("FAIL write_while_full fifo_write=1 fifo_full=1 expected no write");
        end
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_extra_write din=%h expected no write", fifo_din);
        end else begin
          mon_exp = sb.pop_front();
          if (fifo_din !== mon_exp) begin
            failures++;
            $display("FAIL sb_din got=%h expected=%h", fifo_din, mon_exp);
          end
        end
      end
      if (trunc_pulse) begin
        trunc_cnt++;
        trunc_at = wr_count;
      end
    end
  end

  // Producer model: hold a beat until accepted, then present the next one.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      if (pq[i].size() > 0 && !hold[i]) begin
        req_valid[i] = 1'b1;
        {req_last[i], req_data[i*WIDTH +: WIDTH]} = pq[i][0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*WIDTH +: WIDTH] = '0;
      end
    end
    fifo_full = full_req;
  end

  task automatic push_beat(input int r, input logic [7:0] d, input logic l);
    pq[r].push_back({l, d});
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    full_req = 1'b0;
    hold     = '0;
    for (int i = 0; i < NREQ; i++) pq[i].delete();
    sb.delete();
    cyc_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n     = 1'b1;
    wr_count  = 0;
    trunc_cnt = 0;
    trunc_at  = 0;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_wr(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #1;
      if (wr_count >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_sb_empty(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b expected=0", busy); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d expected=0", grant_id); end
    checks++; if (trunc_pulse !== 1'b0) begin failures++; $display("FAIL reset_trunc got=%0b expected=0", trunc_pulse); end
    checks++;
    if ({req_ready, fifo_write, fifo_din} !== '0) begin
      failures++;
      $display("FAIL reset_outputs ready=%b write=%b din=%h expected all 0", req_ready, fifo_write, fifo_din);
    end
    do_reset();
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    push_beat(1, 8'hA1, 1'b0); push_beat(1, 8'hA2, 1'b0); push_beat(1, 8'hA3, 1'b1);
    sb.push_back(8'hA1); sb.push_back(8'hA2); sb.push_back(8'hA3);
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || fifo_write !== 1'b0) begin failures++; $display("FAIL single_bubble busy=%0b write=%0b expected 0 0", busy, fifo_write); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (busy !== 1'b1 || grant_id !== 2'd1 || fifo_write !== 1'b1 || req_ready !== 4'b0010) begin
        failures++;
        $display("FAIL single_beat%0d busy=%0b grant=%0d write=%0b ready=%b expected 1 1 1 0010", c, busy, grant_id, fifo_write, req_ready);
      end
    end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_release busy=%0b expected 0", busy); end
    wait_sb_empty(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_drain left=%0d expected 0", sb.size()); end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    push_beat(0, 8'h01, 1'b1); push_beat(0, 8'h02, 1'b1);
    push_beat(1, 8'h11, 1'b1); push_beat(2, 8'h21, 1'b1); push_beat(3, 8'h31, 1'b1);
    sb.push_back(8'h01); sb.push_back(8'h11); sb.push_back(8'h21);
    sb.push_back(8'h31); sb.push_back(8'h02);
    wait_sb_empty(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr_drain left=%0d expected 0", sb.size()); end
    checks++; if (cyc_q.size() != 5) begin failures++; $display("FAIL rr_writes got=%0d expected=5", cyc_q.size()); end
    for (int i = 1; i < cyc_q.size(); i++) begin
      checks++;
      if (cyc_q[i] - cyc_q[i-1] != 2) begin
        failures++;
        $display("FAIL rr_spacing idx=%0d got=%0d expected=2", i, cyc_q[i] - cyc_q[i-1]);
      end
    end
  endtask

  task automatic test_truncate();
    bit ok;
    do_reset();
    for (int k = 0; k < 20; k++) push_beat(2, 8'h40 + 8'(k), k == 19);
    push_beat(3, 8'h3F, 1'b1);
    for (int k = 0; k < 16; k++) sb.push_back(8'h40 + 8'(k));
    sb.push_back(8'h3F);
    for (int k = 16; k < 20; k++) sb.push_back(8'h40 + 8'(k));
    wait_sb_empty(100, ok);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (!ok) begin failures++; $display("FAIL trunc_drain left=%0d expected 0", sb.size()); end
    checks++; if (trunc_cnt != 1) begin failures++; $display("FAIL trunc_count got=%0d expected=1", trunc_cnt); end
    checks++; if (trunc_at != 16) begin failures++; $display("FAIL trunc_position got=%0d expected=16", trunc_at); end
    checks++; if (wr_count != 21) begin failures++; $display("FAIL trunc_writes got=%0d expected=21", wr_count); end
  endtask

  task automatic test_exact_max();
    bit ok;
    do_reset();
    for (int k = 0; k < MAXB; k++) begin
      push_beat(1, 8'hC0 + 8'(k), k == MAXB - 1);
      sb.push_back(8'hC0 + 8'(k));
    end
    wait_sb_empty(60, ok);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (!ok) begin failures++; $display("FAIL exact_drain left=%0d expected 0", sb.size()); end
    checks++; if (trunc_cnt != 0) begin failures++; $display("FAIL exact_trunc got=%0d expected=0", trunc_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL exact_busy got=%0b expected=0", busy); end
  endtask

  task automatic test_full_stall();
    bit ok;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      push_beat(0, 8'h60 + 8'(k), k == 7);
      sb.push_back(8'h60 + 8'(k));
    end
    wait_wr(2, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_start writes=%0d expected>=2", wr_count); end
    full_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++;
      if (fifo_write !== 1'b0 || req_ready !== 4'b0000 || grant_id !== 2'd0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL full_stall%0d write=%0b ready=%b grant=%0d busy=%0b expected 0 0000 0 1", c, fifo_write, req_ready, grant_id, busy);
      end
    end
    full_req = 1'b0;
    @(negedge clk); #1;
    checks++; if (fifo_write !== 1'b1) begin failures++; $display("FAIL full_resume write=%0b expected=1", fifo_write); end
    wait_sb_empty(30, ok);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (!ok) begin failures++; $display("FAIL full_drain left=%0d expected 0", sb.size()); end
    checks++; if (wr_count != 8) begin failures++; $display("FAIL full_writes got=%0d expected=8", wr_count); end
  endtask

  task automatic test_valid_drop();
    bit ok;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      push_beat(0, 8'h70 + 8'(k), k == 5);
      sb.push_back(8'h70 + 8'(k));
    end
    push_beat(1, 8'h7A, 1'b1); push_beat(2, 8'h7B, 1'b1);
    sb.push_back(8'h7A); sb.push_back(8'h7B);
    wait_wr(2, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL drop_start writes=%0d expected>=2", wr_count); end
    hold[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (fifo_write !== 1'b0 || req_ready !== 4'b0000 || grant_id !== 2'd0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL drop_hold%0d write=%0b ready=%b grant=%0d busy=%0b expected 0 0000 0 1", c, fifo_write, req_ready, grant_id, busy);
      end
    end
    hold[0] = 1'b0;
    wait_sb_empty(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL drop_drain left=%0d expected 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    push_beat(0, 8'h80, 1'b1);
    for (int k = 0; k < 6; k++) push_beat(2, 8'h90 + 8'(k), k == 5);
    sb.push_back(8'h80); sb.push_back(8'h90); sb.push_back(8'h91);
    wait_wr(3, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_start writes=%0d expected>=3", wr_count); end
    @(posedge clk); #2;
    checks++; if (busy !== 1'b1 || grant_id !== 2'd2) begin failures++; $display("FAIL rstmid_locked busy=%0b grant=%0d expected 1 2", busy, grant_id); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || req_ready !== 4'b0000 || fifo_write !== 1'b0 || fifo_din !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_abort busy=%0b ready=%b write=%0b din=%h expected 0 0000 0 00", busy, req_ready, fifo_write, fifo_din);
    end
    do_reset();
    push_beat(1, 8'h91, 1'b1); push_beat(0, 8'h81, 1'b1);
    sb.push_back(8'h81); sb.push_back(8'h91);
    wait_wr(1, 20, ok);
    checks++; if (!ok || grant_id !== 2'd0) begin failures++; $display("FAIL rstmid_first_grant grant=%0d ok=%0b expected 0 1", grant_id, ok); end
    wait_sb_empty(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_drain left=%0d expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_truncate();
    test_exact_max();
    test_full_stall();
    test_valid_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
